// File: rtl/transform_mac_engine_pkg.sv
// Shared state type, default memory map and DOT_PROD_WIDTH reduction helpers
// for transform_mac_engine.
package transform_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, FETCH_F, COMPUTE, DONE} state_t;

  localparam logic [12:0] DEF_WEIGHT_BASE  = 13'h000;
  localparam logic [12:0] DEF_FEATURE_BASE = 13'h200;

  function automatic logic signed [63:0] upper_bound(input int dw, input logic sgn);
    return sgn ? (64'sd1 <<< (dw - 1)) - 64'sd1 : (64'sd1 <<< dw) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] lower_bound(input int dw, input logic sgn);
    return sgn ? -(64'sd1 <<< (dw - 1)) : 64'sd0;
  endfunction

  function automatic logic out_of_range(input logic signed [63:0] acc, input int dw,
                                        input logic sgn);
    return (acc > upper_bound(dw, sgn)) || (acc < lower_bound(dw, sgn));
  endfunction

  // Wrap keeps the value so the caller's truncation yields the low bits.
  function automatic logic signed [63:0] clamp(input logic signed [63:0] acc, input int dw,
                                               input logic sgn, input logic sat);
    if (sat && (acc > upper_bound(dw, sgn))) return upper_bound(dw, sgn);
    if (sat && (acc < lower_bound(dw, sgn))) return lower_bound(dw, sgn);
    return acc;
  endfunction

endpackage

// File: rtl/transform_mac_engine_dot_product_unit.sv
// Combinational dot product of one feature row with one weight column,
// signed or unsigned operands, exact result in ACC_W bits.
module dot_product_unit #(
  parameter int N        = 96,
  parameter int IN_WIDTH = 5,
  parameter int ACC_W    = 17
) (
  input  logic                          signed_mode,
  input  logic [N-1:0][IN_WIDTH-1:0]    feature,
  input  logic [N-1:0][IN_WIDTH-1:0]    weight,
  output logic [ACC_W-1:0]              sum
);

  localparam int PW = 2 * IN_WIDTH + 2;

  logic signed [PW-1:0] fx, wx, prod;
  logic [ACC_W-1:0]     acc;

  // The true sum always fits ACC_W bits, so modular accumulation is exact.
  always_comb begin
    acc  = '0;
    fx   = '0;
    wx   = '0;
    prod = '0;
    for (int i = 0; i < N; i++) begin
      fx   = {{(IN_WIDTH + 2){signed_mode & feature[i][IN_WIDTH-1]}}, feature[i]};
      wx   = {{(IN_WIDTH + 2){signed_mode & weight[i][IN_WIDTH-1]}}, weight[i]};
      prod = fx * wx;
      acc  = acc + ACC_W'(prod);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/transform_mac_engine.sv
// Feature x weight matrix product: loads weight columns, then streams feature
// rows, one result column per cycle, into a combinationally readable buffer.
module transform_mac_engine
  import transform_pkg::*;
#(
  parameter int FEATURE_ROWS   = 6,
  parameter int FEATURE_COLS   = 96,
  parameter int WEIGHT_COLS    = 3,
  parameter int IN_WIDTH       = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 13,
  parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_BASE  = ADDRESS_WIDTH'(DEF_WEIGHT_BASE),
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = ADDRESS_WIDTH'(DEF_FEATURE_BASE),
  parameter int MEM_LATENCY    = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        signed_mode,
  input  logic                                        saturate,
  input  logic [FEATURE_COLS-1:0][IN_WIDTH-1:0]       data_in,
  input  logic [$clog2(FEATURE_ROWS)-1:0]             read_row,
  output logic [ADDRESS_WIDTH-1:0]                    read_address,
  output logic                                        enable_read,
  output logic                                        busy,
  output logic                                        done_trans,
  output logic                                        overflow,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_row_out
);

  localparam int RW    = $clog2(FEATURE_ROWS);
  localparam int CW    = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int LW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int ACC_W = 2 * IN_WIDTH + $clog2(FEATURE_COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(FEATURE_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WEIGHT_COLS - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(MEM_LATENCY - 1);

  state_t                                   state;
  logic [RW-1:0]                            row;
  logic [CW-1:0]                            col;
  logic [LW-1:0]                            lat;
  logic                                     signed_q, sat_q;
  logic [FEATURE_COLS-1:0][IN_WIDTH-1:0]    weight_q [WEIGHT_COLS];
  logic [FEATURE_COLS-1:0][IN_WIDTH-1:0]    feature_q;
  logic [DOT_PROD_WIDTH-1:0]                result_q [FEATURE_ROWS][WEIGHT_COLS];
  logic [ACC_W-1:0]                         sum;
  logic signed [63:0]                       acc_ext;

  dot_product_unit #(
    .N        (FEATURE_COLS),
    .IN_WIDTH (IN_WIDTH),
    .ACC_W    (ACC_W)
  ) u_dot (
    .signed_mode (signed_q),
    .feature     (feature_q),
    .weight      (weight_q[col]),
    .sum         (sum)
  );

  assign acc_ext = signed_q ? {{(64 - ACC_W){sum[ACC_W-1]}}, sum}
                            : {{(64 - ACC_W){1'b0}}, sum};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      enable_read  <= 1'b0;
      read_address <= '0;
      busy         <= 1'b0;
      done_trans   <= 1'b0;
      overflow     <= 1'b0;
      row          <= '0;
      col          <= '0;
      lat          <= '0;
      signed_q     <= 1'b0;
      sat_q        <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++)
        for (int c = 0; c < WEIGHT_COLS; c++) result_q[r][c] <= '0;
    end else begin
      enable_read  <= 1'b0;
      read_address <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            signed_q     <= signed_mode;
            sat_q        <= saturate;
            overflow     <= 1'b0;
            done_trans   <= 1'b0;
            busy         <= 1'b1;
            row          <= '0;
            col          <= '0;
            lat          <= '0;
            enable_read  <= 1'b1;
            read_address <= WEIGHT_BASE;
            state        <= LOAD_W;
            for (int r = 0; r < FEATURE_ROWS; r++)
              for (int c = 0; c < WEIGHT_COLS; c++) result_q[r][c] <= '0;
          end
        end
        LOAD_W: begin
          if (lat == LAST_LAT) begin
            weight_q[col] <= data_in;
            lat           <= '0;
            enable_read   <= 1'b1;
            if (col == LAST_COL) begin
              col          <= '0;
              read_address <= FEATURE_BASE;
              state        <= FETCH_F;
            end else begin
              col          <= col + CW'(1);
              read_address <= WEIGHT_BASE + ADDRESS_WIDTH'(col) + ADDRESS_WIDTH'(1);
            end
          end else begin
            lat <= lat + LW'(1);
          end
        end
        FETCH_F: begin
          if (lat == LAST_LAT) begin
            feature_q <= data_in;
            lat       <= '0;
            col       <= '0;
            state     <= COMPUTE;
          end else begin
            lat <= lat + LW'(1);
          end
        end
        COMPUTE: begin
          result_q[row][col] <= DOT_PROD_WIDTH'(clamp(acc_ext, DOT_PROD_WIDTH, signed_q, sat_q));
          if (out_of_range(acc_ext, DOT_PROD_WIDTH, signed_q)) overflow <= 1'b1;
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) begin
              busy       <= 1'b0;
              done_trans <= 1'b1;
              state      <= DONE;
            end else begin
              row          <= row + RW'(1);
              enable_read  <= 1'b1;
              read_address <= FEATURE_BASE + ADDRESS_WIDTH'(row) + ADDRESS_WIDTH'(1);
              state        <= FETCH_F;
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range row selects read as zero.
  always_comb begin
    fm_wm_row_out = '0;
    if ({1'b0, read_row} < (RW + 1)'(FEATURE_ROWS))
      for (int c = 0; c < WEIGHT_COLS; c++) fm_wm_row_out[c] = result_q[read_row][c];
  end

endmodule

// File: doc/transform_mac_engine.md
# transform_mac_engine

Parametrised successor to the GCN feature×weight transformation stage. It computes the product of the feature matrix (FEATURE_ROWS×FEATURE_COLS) and the weight matrix (FEATURE_COLS×WEIGHT_COLS) by fetching whole rows over the shared memory read port. Over the existing stage it adds configurable memory read latency, signed/unsigned operands, a wrap-or-saturate output mode, and a sticky overflow flag. Results are held in an internal buffer that the downstream aggregation stage reads through `read_row`.

## Interface
- FEATURE_ROWS, 6, feature matrix rows (graph nodes)
- FEATURE_COLS, 96, feature length (= weight matrix rows)
- WEIGHT_COLS, 3, output columns
- IN_WIDTH, 5, width of each feature and weight element
- DOT_PROD_WIDTH, 16, output element width
- ADDRESS_WIDTH, 13, memory address width
- WEIGHT_BASE, 13'h000, address of weight column 0; column c is at WEIGHT_BASE+c
- FEATURE_BASE, 13'h200, address of feature row 0; row r is at FEATURE_BASE+r
- MEM_LATENCY, 1, cycles from request to `data_in` valid (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse that begins a run
- signed_mode  in  1  1 = two's-complement operands; latched at start
- saturate  in  1  1 = saturate, 0 = wrap; latched at start
- data_in  in  [IN_WIDTH] × FEATURE_COLS  row returned by memory
- read_row  in  clog2(FEATURE_ROWS)  result buffer row select
- read_address  out  ADDRESS_WIDTH  memory request address
- enable_read  out  1  memory request strobe
- busy  out  1  run in progress
- done_trans  out  1  run complete; level signal
- overflow  out  1  sticky: some result fell outside the DOT_PROD_WIDTH range
- fm_wm_row_out  out  [DOT_PROD_WIDTH] × WEIGHT_COLS  result row `read_row`, combinational

## Operation
- FSM states: IDLE → LOAD_W → FETCH_F → COMPUTE → DONE.
- IDLE or DONE with start=1:
  - latch signed_mode and saturate;
  - clear the result buffer and overflow;
  - drop done_trans, raise busy;
  - go to LOAD_W.
- start while busy is ignored.
- LOAD_W: for each c = 0..WEIGHT_COLS-1, issue one read of WEIGHT_BASE+c and store `data_in` as internal weight column c. After the last column, go to FETCH_F.
- FETCH_F: read FEATURE_BASE+r into the feature register, then go to COMPUTE.
- COMPUTE: one weight column c per cycle. Write result[r][c] = Σi f[i]·w[c][i].
  - After c = WEIGHT_COLS-1: go to FETCH_F with r+1, or to DONE if r was the last row.
- DONE: busy=0, done_trans=1. Stay until start or reset.
- Arithmetic:
  - Products are 2·IN_WIDTH bits, signed or unsigned per the latched mode.
  - Accumulate at full width, 2·IN_WIDTH + clog2(FEATURE_COLS) bits, with no internal loss.
  - Reduce to DOT_PROD_WIDTH: wrap keeps the low bits; saturate clamps to [0, 2^D−1] unsigned or [−2^(D−1), 2^(D−1)−1] signed.
  - overflow is set on any out-of-range result, whether or not saturate is set.
- Readout:
  - fm_wm_row_out follows read_row combinationally at all times.
  - read_row ≥ FEATURE_ROWS returns all zeros.
  - Rows not yet computed in the current run read 0.

## Timing
- Read protocol:
  - enable_read is high for exactly one cycle per read; read_address is valid in that cycle and is 0 when idle.
  - `data_in` is sampled on the rising edge that ends cycle t+MEM_LATENCY−1, where t is the request cycle.
  - Reads never overlap; each read occupies MEM_LATENCY cycles.
- Run length: done_trans rises WEIGHT_COLS·L + FEATURE_ROWS·(L + WEIGHT_COLS) cycles after the start edge (27 at defaults).
- Reset (reset=0 at an edge) from any state, including mid-run:
  - state goes to IDLE;
  - enable_read, read_address, busy, done_trans and overflow go to 0;
  - the result buffer clears, so fm_wm_row_out = 0.
- start and reset asserted together: reset wins.

## Structure
- Package `transform_pkg` holds:
  - the state enum typedef;
  - a `clamp` function for the DOT_PROD_WIDTH reduction (wrap/saturate, signed/unsigned);
  - the default base-address constants.
- Sub-module `dot_product_unit` is combinational: one feature row × one weight column, taking signed_mode and returning the full-width sum.
- The top level holds the FSM, counters, weight/feature registers and result buffer.

## Test plan
- Unsigned run at defaults:
  - stimulus: every feature = 1, every weight = 2;
  - response: all 18 results = 192; done_trans rises 27 cycles after start; overflow = 0.
- Wrap vs saturate, unsigned:
  - stimulus: all elements = 31 (96·961 = 92256);
  - response with saturate=0: results 26720, overflow = 1;
  - response with saturate=1: results 65535, overflow = 1.
- Signed mode:
  - stimulus: features = 5'b11111 (−1), weights = 2;
  - response: results = 16'hFF40 (−192), overflow = 0.
- MEM_LATENCY = 3:
  - response: single-cycle strobes at 0x000–0x002, then 0x200–0x205;
  - done_trans after 45 cycles; results match the golden model.
- Reset mid-run:
  - stimulus: reset = 0 in cycle 10;
  - response: after the next edge all outputs are 0 and state is IDLE; a fresh start gives correct results.
- start while busy and out-of-range readout:
  - stimulus: pulse start while busy; set read_row = 6;
  - response: the run timing is unchanged; fm_wm_row_out reads all zeros.
